// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM states, legal oversample
// settings, parity selectors and frame bit positions.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int unsigned PRESC_8X  = 7;
  localparam int unsigned PRESC_16X = 15;
  localparam int unsigned PRESC_32X = 31;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [3:0] PARITY_BIT_IDX = 4'd9;
  localparam logic [3:0] STOP_BIT_IDX   = 4'd10;

  function automatic logic presc_legal(input int unsigned p);
    return (p == PRESC_8X) || (p == PRESC_16X) || (p == PRESC_32X);
  endfunction

  // Zero-extension of the payload does not change its parity.
  function automatic logic parity_bit(input logic [31:0] d, input logic ptype);
    return (^d) ^ (ptype == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample tick counter (edge_count) and frame bit index (bit_count);
// the bit index advances each time the tick counter wraps at presc.
module uart_rx_edge_bit_counter #(
  parameter int unsigned PRESC_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic [PRESC_W-1:0] edge_count,
  output logic [3:0]         bit_count
);

  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [3:0]         bit_q, bit_d;

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clr) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (en) begin
      if (edge_q == presc) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_count = edge_q;
  assign bit_count  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detection, deserialisation (LSB first),
// parity/stop checking and single-cycle result flags.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic                  parity_en,
  input  logic                  parity_type,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [PRESC_W-1:0]    edge_count,
  output logic [3:0]            bit_count,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  glitch_q, glitch_d;

  logic                  busy, decide, abort;
  logic [IDX_W-1:0]      idx;

  assign busy   = (state_q != ST_IDLE);
  assign decide = busy && (edge_count == presc_q);
  assign abort  = busy && (prescale != presc_q);
  assign idx    = IDX_W'(bit_count - 4'd1);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    p_data_d   = p_data_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;
    glitch_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_in && presc_legal(32'(prescale))) begin
          state_d    = ST_START;
          presc_d    = prescale;
          par_en_d   = parity_en;
          par_type_d = parity_type;
          err_d      = 1'b0;
        end
      end
      ST_START: begin
        if (decide) begin
          if (sampled_bit) begin
            glitch_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (decide) begin
          p_data_d[idx] = sampled_bit;
          if (bit_count == 4'(DATA_WIDTH)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (decide) begin
          if (sampled_bit != parity_bit(32'(p_data_q), par_type_q)) begin
            err_d = 1'b1;
          end
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide) begin
          if (!sampled_bit) begin
            stp_err_d = 1'b1;
          end else if (err_q) begin
            par_err_d = 1'b1;
          end else begin
            valid_d = 1'b1;
          end
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A prescale change mid-frame drops the frame silently, like reset.
    if (abort) begin
      state_d   = ST_IDLE;
      err_d     = 1'b0;
      valid_d   = 1'b0;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;
      glitch_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
      p_data_q   <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      glitch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      p_data_q   <= p_data_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
      glitch_q   <= glitch_d;
    end
  end

  uart_rx_edge_bit_counter #(
    .PRESC_W(PRESC_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (busy),
    .clr       (state_d == ST_IDLE),
    .presc     (presc_q),
    .edge_count(edge_count),
    .bit_count (bit_count)
  );

  assert property (@(posedge clk) disable iff (rst) bit_count <= STOP_BIT_IDX);
  assert property (@(posedge clk) disable iff (rst)
                   (state_q == ST_PARITY) |-> (bit_count == PARITY_BIT_IDX));

  assign dat_samp_en = busy;
  assign p_data      = p_data_q;
  assign data_valid  = valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign strt_glitch = glitch_q;

endmodule
